// File: rtl/mips150_io_pkg.sv
// Shared definitions for the MIPS150 memory-mapped serial block: register
// offsets, STATUS bit positions and the UART FSM state type.
package mips150_io_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_RX_DATA = 2'd1;
    localparam logic [1:0] REG_TX_DATA = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_TX_READY    = 0;
    localparam int ST_RX_VALID    = 1;
    localparam int ST_RX_OVERRUN  = 2;
    localparam int ST_FRAMING_ERR = 3;
    localparam int ST_LOOPBACK    = 4;

    localparam int CTRL_LOOPBACK  = 0;
    localparam int CTRL_CLR_FLAGS = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mips150_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop may coincide at any
// occupancy, and a pop on empty is ignored.
module mips150_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mips150_uart_mmio.sv
// Memory-mapped UART for MIPS150: STATUS/RX_DATA/TX_DATA/CTRL window over TX and
// RX FIFOs. Define UART_MMIO_LOOPBACK_EN to add the CTRL-controlled internal loopback.
module mips150_uart_mmio
    import mips150_io_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  io_addr,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        serial_in,
    output logic        serial_out
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [1:0] reg_sel;
    logic       wr_tx, wr_ctrl, rd_rx;
    assign reg_sel = io_addr[3:2];
    assign wr_tx   = io_we && (reg_sel == REG_TX_DATA);
    assign wr_ctrl = io_we && (reg_sel == REG_CTRL);
    assign rd_rx   = io_re && (reg_sel == REG_RX_DATA);

    logic                 unused_bits;
    assign unused_bits = ^{io_wdata, io_addr[1:0]};

    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic                 tx_full, tx_empty, tx_pop;
    logic                 rx_full, rx_empty, rx_pop, rx_push;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    assign rx_pop = rd_rx && !rx_empty;

    mips150_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_tx),
        .wdata_i (io_wdata[DATA_BITS-1:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    mips150_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .wdata_i (rx_shift_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    uart_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_out_q, tx_out_d;

    assign serial_out = tx_out_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_out_d   = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_out_d   = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_out_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_out_d   = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    logic [1:0] sync_q;
    logic       rx_in, rx_prev_q;

`ifdef UART_MMIO_LOOPBACK_EN
    logic loopback_q, loopback_d;
    assign loopback_d = wr_ctrl ? io_wdata[CTRL_LOOPBACK] : loopback_q;
    assign rx_in      = loopback_q ? tx_out_q : sync_q[1];
`else
    assign rx_in = sync_q[1];
`endif

    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic             frame_err_set;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_in) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_in ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) rx_state_d = S_STOP;
                    else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d      = '0;
                    rx_state_d    = S_IDLE;
                    rx_push       = rx_in;
                    frame_err_set = !rx_in;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    logic overrun_q, overrun_d, frame_err_q, frame_err_d, clr_flags;
    logic [31:0] status, rdata_q, rdata_d;

    assign clr_flags = wr_ctrl && io_wdata[CTRL_CLR_FLAGS];

    // Set is applied after clear so a coincident event is never lost.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (clr_flags) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_push && rx_full && !rx_pop) overrun_d   = 1'b1;
        if (frame_err_set)                 frame_err_d = 1'b1;
    end

    always_comb begin
        status                 = '0;
        status[ST_TX_READY]    = !tx_full;
        status[ST_RX_VALID]    = !rx_empty;
        status[ST_RX_OVERRUN]  = overrun_q;
        status[ST_FRAMING_ERR] = frame_err_q;
`ifdef UART_MMIO_LOOPBACK_EN
        status[ST_LOOPBACK]    = loopback_q;
`endif
    end

    always_comb begin
        rdata_d = rdata_q;
        if (io_re) begin
            rdata_d = '0;
            if (reg_sel == REG_STATUS)              rdata_d = status;
            else if (reg_sel == REG_RX_DATA && !rx_empty) rdata_d = 32'(rx_head);
        end
    end

    assign io_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_out_q    <= 1'b1;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
`ifdef UART_MMIO_LOOPBACK_EN
            loopback_q  <= 1'b0;
`endif
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_out_q    <= tx_out_d;
            sync_q      <= {sync_q[0], serial_in};
            rx_prev_q   <= rx_in;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
`ifdef UART_MMIO_LOOPBACK_EN
            loopback_q  <= loopback_d;
`endif
        end
    end

endmodule

// File: tb/tb_mips150_uart_mmio.sv
// Scoreboard bench for mips150_uart_mmio: MMIO read responses and decoded TX
// frames are checked by monitors against queues filled by the stimulus.
module tb_mips150_uart_mmio;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  io_addr = '0;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        serial_in = 1'b1;
    logic        serial_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t       rd_q[$];
    logic [7:0] tx_q[$];

    mips150_uart_mmio #(
        .CLOCK_FREQ (100),
        .BAUD_RATE  (10),
        .DATA_BITS  (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .io_we      (io_we),
        .io_re      (io_re),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: a read strobe seen at a rising edge has its data checked on the next falling edge.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = io_re && !rst;
            @(negedge clk);
            if (pend) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_q.size()), 32'd1);
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, io_rdata, e.value);
                end
            end
        end
    end

    // TX monitor: checks every cycle of each frame against the expected byte.
    initial begin
        logic [9:0] frame, got;
        logic [7:0] b;
        int         bad;
        forever begin
            @(negedge clk);
            if (!rst && serial_out === 1'b0) begin
                check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
                b     = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                frame = {1'b1, b, 1'b0};
                got   = '0;
                bad   = 0;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (serial_out !== frame[i / CPB]) bad++;
                    if (i % CPB == CPB / 2) got[i / CPB] = serial_out;
                end
                check("tx_frame_bits", 32'(got), 32'(frame));
                check("tx_frame_timing", 32'(bad), 32'd0);
            end
        end
    end

    task automatic mmio_read(input logic [1:0] r, input logic [31:0] exp, input string name);
        exp_t e;
        e.name  = name;
        e.value = exp;
        rd_q.push_back(e);
        io_addr = {r, 2'b00};
        io_re   = 1'b1;
        @(negedge clk);
        io_re   = 1'b0;
    endtask

    task automatic mmio_write(input logic [1:0] r, input logic [31:0] data);
        io_addr  = {r, 2'b00};
        io_wdata = data;
        io_we    = 1'b1;
        @(negedge clk);
        io_we    = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_serial_out", 32'(serial_out), 32'd1);
        mmio_read(2'd0, 32'h1, "reset_status");

        // Single frame 0xA5 with exact start latency
        tx_q.push_back(8'hA5);
        mmio_write(2'd2, 32'hA5);
        check("tx_idle_at_write_edge", 32'(serial_out), 32'd1);
        @(negedge clk);
        check("tx_start_latency", 32'(serial_out), 32'd0);
        repeat (30) @(negedge clk);
        mmio_read(2'd0, 32'h1, "status_during_tx");
        repeat (80) @(negedge clk);

        // Fill the TX FIFO: 0x00 leaves at once, 0x01..0x08 fill it, 0xFF is dropped
        for (int i = 0; i < 9; i++) begin
            tx_q.push_back(8'(i));
            mmio_write(2'd2, 32'(i));
        end
        mmio_write(2'd2, 32'hFF);
        mmio_read(2'd0, 32'h0, "status_tx_full");
        repeat (9 * 10 * CPB + 20) @(negedge clk);
        mmio_read(2'd0, 32'h1, "status_tx_drained");

        // Receive one good byte
        send_rx(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        mmio_read(2'd0, 32'h3, "status_rx_valid");
        mmio_read(2'd1, 32'h3C, "rx_data_3c");
        mmio_read(2'd0, 32'h1, "status_after_pop");
        mmio_read(2'd1, 32'h0, "rx_read_empty");

        // Framing error
        send_rx(8'h55, 1'b0);
        serial_in = 1'b1;
        repeat (10) @(negedge clk);
        mmio_read(2'd0, 32'h9, "status_framing_err");
        mmio_read(2'd1, 32'h0, "rx_no_data_after_ferr");
        mmio_write(2'd3, 32'h2);
        mmio_read(2'd0, 32'h1, "status_after_clear");

        // Overrun: nine frames into an eight-entry FIFO
        for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1);
        serial_in = 1'b1;
        repeat (10) @(negedge clk);
        mmio_read(2'd0, 32'h7, "status_overrun");
        for (int i = 0; i < 8; i++) mmio_read(2'd1, 32'h10 + 32'(i), "rx_overrun_order");
        mmio_read(2'd0, 32'h5, "status_overrun_sticky");
        mmio_write(2'd3, 32'h2);
        mmio_read(2'd0, 32'h1, "status_overrun_cleared");

        repeat (5) @(negedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
